// File: rtl/key_digit_entry_pkg.sv
// Shared encodings for the key-driven digit entry front end: key indices,
// decoded actions and entry FSM states.
package key_digit_entry_pkg;

  localparam int unsigned K_ENTER = 0;
  localparam int unsigned K_DIGIT = 1;
  localparam int unsigned K_CLR   = 2;
  localparam int unsigned K_DEL   = 3;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_DIGIT,
    ACT_DEL,
    ACT_ENTER,
    ACT_CLR
  } action_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_EDIT,
    S_FULL
  } state_t;

  // Only the highest-priority pulse in a cycle becomes an action.
  function automatic action_t decode_action(input logic [3:0] pulses);
    if (pulses[K_CLR])        return ACT_CLR;
    else if (pulses[K_DEL])   return ACT_DEL;
    else if (pulses[K_ENTER]) return ACT_ENTER;
    else if (pulses[K_DIGIT]) return ACT_DIGIT;
    else                      return ACT_NONE;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-flop synchroniser, stable-state debounce counter and
// a one-cycle press pulse on each debounced 1->0 transition.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic [1:0]       sync;
  logic             stable;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  // The synchroniser resets to the pressed level and pulses stay disarmed
  // until a released level is seen, so a key held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      stable <= 1'b1;
      armed  <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      pulse <= 1'b0;
      if (sync[1] && stable) armed <= 1'b1;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= ~stable;
        pulse  <= stable & armed;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_digit_entry.sv
// Operator input front end: debounced KEY presses drive a hex digit entry
// register and commit it as a 32-bit operand on ENTER.
module key_digit_entry
  import key_digit_entry_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned NDIG      = 8
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic [3:0]  KEY,
  input  logic [3:0]  SW,
  output logic [31:0] ENTRY,
  output logic [3:0]  DIGITS,
  output logic [31:0] DATA_OUT,
  output logic        DATA_VALID,
  output logic        OVF_LED,
  output logic [3:0]  KEY_PULSE
);

  localparam int unsigned EW = 4 * NDIG;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (CLOCK_50),
      .rst_n (RST_N),
      .key   (KEY[k]),
      .pulse (KEY_PULSE[k])
    );
  end

  action_t        act;
  state_t         state_q, state_d;
  logic [EW-1:0]  entry_q, entry_d;
  logic [3:0]     digits_q, digits_d;
  logic [31:0]    data_q, data_d;
  logic           valid_q, valid_d;
  logic           ovf_q, ovf_d;

  assign act = decode_action(KEY_PULSE);

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_EMPTY;
      entry_q  <= '0;
      digits_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      digits_q <= digits_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    digits_d = digits_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    case (act)
      ACT_DIGIT: begin
        if (state_q == S_FULL) begin
          ovf_d = 1'b1;
        end else begin
          entry_d  = (entry_q << 4) | EW'(SW);
          digits_d = digits_q + 4'd1;
          state_d  = (digits_d == 4'(NDIG)) ? S_FULL : S_EDIT;
        end
      end
      ACT_DEL: begin
        ovf_d = 1'b0;
        if (state_q != S_EMPTY) begin
          entry_d  = entry_q >> 4;
          digits_d = digits_q - 4'd1;
          state_d  = (digits_d == 4'd0) ? S_EMPTY : S_EDIT;
        end
      end
      ACT_ENTER: begin
        data_d   = 32'(entry_q);
        valid_d  = 1'b1;
        entry_d  = '0;
        digits_d = '0;
        ovf_d    = 1'b0;
        state_d  = S_EMPTY;
      end
      ACT_CLR: begin
        entry_d  = '0;
        digits_d = '0;
        ovf_d    = 1'b0;
        state_d  = S_EMPTY;
      end
      default: ;
    endcase
  end

  assign ENTRY      = 32'(entry_q);
  assign DIGITS     = digits_q;
  assign DATA_OUT   = data_q;
  assign DATA_VALID = valid_q;
  assign OVF_LED    = ovf_q;

endmodule
